painterengine_gpu_gpuinfo_client: RTL and testbench

PAINTERENGINE_GPU_GPUINFO_CLIENT -- requirements
Module: painterengine_gpu_gpuinfo_client

---
 rtl/painterengine_gpu_gpuinfo_client.sv | 171 +++++++++++++++++
 tb/tb_painterengine_gpu_gpuinfo_client.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/painterengine_gpu_gpuinfo_client.sv
// Host-side client for the GPU info unit: one request in flight, clear pulse after every op.
// Optional watchdog on WAIT/SETTLE enabled by defining GPUINFO_CLIENT_TIMEOUT_EN.
module painterengine_gpu_gpuinfo_client #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        i_wire_clock,
  input  logic        i_wire_reset,
  input  logic        i_wire_req_valid,
  output logic        o_wire_req_ready,
  input  logic [31:0] i_wire_req_opcode,
  output logic        o_wire_resp_valid,
  input  logic        i_wire_resp_ready,
  output logic [31:0] o_wire_resp_data,
  output logic [1:0]  o_wire_resp_status,
  output logic        o_wire_busy,
  output logic [31:0] o_wire_opcode,
  output logic        o_wire_unit_resetn,
  input  logic [31:0] i_wire_state,
  input  logic [31:0] i_wire_return
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StWait   = 3'd1;
  localparam logic [2:0] StClear  = 3'd2;
  localparam logic [2:0] StSettle = 3'd3;
  localparam logic [2:0] StResp   = 3'd4;

  localparam logic [1:0] StatusOk      = 2'd0;
  localparam logic [1:0] StatusError   = 2'd1;
  localparam logic [1:0] StatusTimeout = 2'd2;

  localparam logic [31:0] UnitIdle  = 32'd0;
  localparam logic [31:0] UnitError = 32'd2;
  localparam logic [31:0] UnitDone  = 32'd3;

  logic [2:0]  state_q, state_d;
  logic [31:0] opcode_q, opcode_d;
  logic        unit_resetn_q, unit_resetn_d;
  logic        req_ready_q, req_ready_d;
  logic        busy_q, busy_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  status_q, status_d;
  logic        timeout_hit;

`ifdef GPUINFO_CLIENT_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;

  // Restarts whenever WAIT or SETTLE is (re)entered; idle elsewhere.
  always_comb begin
    cnt_d = '0;
    if ((state_d == StWait || state_d == StSettle) && state_d == state_q) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge i_wire_clock) begin
    if (i_wire_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_hit = (cnt_q == TIMEOUT_CYCLES - 32'd1);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    resp_valid_d = resp_valid_q;
    data_d       = data_q;
    status_d     = status_q;

    case (state_q)
      StIdle: begin
        if (i_wire_req_valid && req_ready_q) begin
          if (i_wire_req_opcode == 32'd0) begin
            state_d  = StClear;
            data_d   = '0;
            status_d = StatusOk;
          end else begin
            state_d  = StWait;
            opcode_d = i_wire_req_opcode;
          end
        end
      end
      StWait: begin
        if (i_wire_state == UnitDone) begin
          state_d  = StClear;
          data_d   = i_wire_return;
          status_d = StatusOk;
        end else if (i_wire_state == UnitError) begin
          state_d  = StClear;
          data_d   = i_wire_return;
          status_d = StatusError;
        end else if (timeout_hit) begin
          state_d  = StClear;
          data_d   = '0;
          status_d = StatusTimeout;
        end
      end
      StClear: begin
        state_d = StSettle;
      end
      StSettle: begin
        if (i_wire_state == UnitIdle) begin
          state_d      = StResp;
          resp_valid_d = 1'b1;
        end else if (timeout_hit) begin
          state_d      = StResp;
          resp_valid_d = 1'b1;
          status_d     = StatusTimeout;
        end
      end
      StResp: begin
        if (i_wire_resp_ready) begin
          state_d      = StIdle;
          resp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d      = StIdle;
        resp_valid_d = 1'b0;
      end
    endcase

    // The clear pulse and opcode drop coincide with the single CLEAR cycle.
    if (state_d == StClear) begin
      opcode_d = '0;
    end
    unit_resetn_d = (state_d != StClear);
    req_ready_d   = (state_d == StIdle);
    busy_d        = (state_d != StIdle);
  end

  always_ff @(posedge i_wire_clock) begin
    if (i_wire_reset) begin
      state_q       <= StIdle;
      opcode_q      <= '0;
      unit_resetn_q <= 1'b0;
      req_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      resp_valid_q  <= 1'b0;
      data_q        <= '0;
      status_q      <= StatusOk;
    end else begin
      state_q       <= state_d;
      opcode_q      <= opcode_d;
      unit_resetn_q <= unit_resetn_d;
      req_ready_q   <= req_ready_d;
      busy_q        <= busy_d;
      resp_valid_q  <= resp_valid_d;
      data_q        <= data_d;
      status_q      <= status_d;
    end
  end

  assign o_wire_req_ready   = req_ready_q;
  assign o_wire_resp_valid  = resp_valid_q;
  assign o_wire_resp_data   = data_q;
  assign o_wire_resp_status = status_q;
  assign o_wire_busy        = busy_q;
  assign o_wire_opcode      = opcode_q;
  assign o_wire_unit_resetn = unit_resetn_q;

endmodule

// File: tb/tb_painterengine_gpu_gpuinfo_client.sv
// Bench for painterengine_gpu_gpuinfo_client: drives it against a small info-unit model,
// table vectors, hand-written corner sequences and randomized transactions.
module tb_painterengine_gpu_gpuinfo_client;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_opcode;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [1:0]  resp_status;
  logic        busy;
  logic [31:0] dut_opcode;
  logic        unit_resetn;
  logic [31:0] unit_state;
  logic [31:0] unit_return;

  always #5 clk = ~clk;

  painterengine_gpu_gpuinfo_client #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .i_wire_clock      (clk),
    .i_wire_reset      (rst),
    .i_wire_req_valid  (req_valid),
    .o_wire_req_ready  (req_ready),
    .i_wire_req_opcode (req_opcode),
    .o_wire_resp_valid (resp_valid),
    .i_wire_resp_ready (resp_ready),
    .o_wire_resp_data  (resp_data),
    .o_wire_resp_status(resp_status),
    .o_wire_busy       (busy),
    .o_wire_opcode     (dut_opcode),
    .o_wire_unit_resetn(unit_resetn),
    .i_wire_state      (unit_state),
    .i_wire_return     (unit_return)
  );

  // Info unit model: IDLE -> PROCESSING -> DONE/ERROR, cleared by unit_resetn.
  logic [1:0]  ustate;
  logic [31:0] uret;
  logic        unit_stuck;
  logic [31:0] tick_q = '0;
  int unsigned resetn_low_cnt = 0;

  assign unit_state  = {30'd0, ustate};
  assign unit_return = uret;

  always @(posedge clk) begin
    tick_q <= tick_q + 32'd1;
    if (!unit_resetn) resetn_low_cnt <= resetn_low_cnt + 1;
  end

  always @(posedge clk) begin
    if (!unit_resetn) begin
      ustate <= 2'd0;
      uret   <= '0;
    end else begin
      case (ustate)
        2'd0: if (dut_opcode != 32'd0) ustate <= 2'd1;
        2'd1: if (!unit_stuck) begin
          case (dut_opcode)
            32'd1:   begin ustate <= 2'd3; uret <= 32'd1;        end
            32'd2:   begin ustate <= 2'd3; uret <= 32'h20240612; end
            32'd3:   begin ustate <= 2'd3; uret <= tick_q;       end
            default: begin ustate <= 2'd2; uret <= 32'd0;        end
          endcase
        end
        default: ;
      endcase
    end
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference: {status, data} a host expects for an opcode, given the unit tick at decode.
  function automatic logic [33:0] ref_resp(input logic [31:0] op, input logic [31:0] tick);
    case (op)
      32'd0:   return {2'd0, 32'd0};
      32'd1:   return {2'd0, 32'd1};
      32'd2:   return {2'd0, 32'h20240612};
      32'd3:   return {2'd0, tick};
      default: return {2'd1, 32'd0};
    endcase
  endfunction

  task automatic do_txn(input string tag, input logic [31:0] op, input int delay,
                        input bit noise, input bit use_model, input logic [1:0] st_in,
                        input logic [31:0] data_in, input bit is_tick);
    int          n;
    int          got_lat;
    int          lat_exp;
    int unsigned low0;
    logic [31:0] t0;
    logic [1:0]  es;
    logic [31:0] ed;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " req_ready"}, {31'd0, req_ready}, 32'd1);
    if (req_ready !== 1'b1) return;
    low0       = resetn_low_cnt;
    req_valid  = 1'b1;
    req_opcode = op;
    t0         = tick_q;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_opcode = $urandom;
    lat_exp    = (op == 32'd0) ? 2 : 5;
    // Unit decodes two edges after the accept edge, so GETTICK returns that tick.
    if (use_model) {es, ed} = ref_resp(op, t0 + 32'd2);
    else begin
      es = st_in;
      ed = is_tick ? t0 + 32'd2 : data_in;
    end
    if (op != 32'd0) check({tag, " opcode_out"}, dut_opcode, op);
    check({tag, " busy"}, {31'd0, busy}, 32'd1);
    got_lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (noise) begin
        req_valid  = 1'($urandom % 2);
        req_opcode = $urandom % 4;
      end
      @(posedge clk); #1;
      if (resp_valid === 1'b1) begin
        got_lat = k;
        break;
      end
    end
    req_valid = 1'b0;
    check({tag, " latency"}, got_lat, lat_exp);
    if (got_lat == 0) return;
    check({tag, " status"}, {30'd0, resp_status}, {30'd0, es});
    check({tag, " data"}, resp_data, ed);
    for (int d = 0; d < delay; d++) begin
      if (noise) req_valid = 1'($urandom % 2);
      @(posedge clk); #1;
      check({tag, " hold_valid"}, {31'd0, resp_valid}, 32'd1);
      check({tag, " hold_data"}, resp_data, ed);
      check({tag, " hold_status"}, {30'd0, resp_status}, {30'd0, es});
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check({tag, " valid_drop"}, {31'd0, resp_valid}, 32'd0);
    check({tag, " busy_after"}, {31'd0, busy}, 32'd0);
    check({tag, " ready_after"}, {31'd0, req_ready}, 32'd1);
    check({tag, " clear_pulses"}, resetn_low_cnt - low0, 32'd1);
  endtask

  typedef struct {
    logic [31:0] op;
    int          delay;
    logic [1:0]  st;
    logic [31:0] data;
    bit          is_tick;
  } vec_t;

  vec_t vecs[7];

  initial begin
    bit   seen;
    logic [31:0] rop;

    vecs[0] = '{op: 32'd1,          delay: 0,  st: 2'd0, data: 32'd1,        is_tick: 1'b0};
    vecs[1] = '{op: 32'd2,          delay: 10, st: 2'd0, data: 32'h20240612, is_tick: 1'b0};
    vecs[2] = '{op: 32'd7,          delay: 0,  st: 2'd1, data: 32'd0,        is_tick: 1'b0};
    vecs[3] = '{op: 32'd1,          delay: 1,  st: 2'd0, data: 32'd1,        is_tick: 1'b0};
    vecs[4] = '{op: 32'd0,          delay: 3,  st: 2'd0, data: 32'd0,        is_tick: 1'b0};
    vecs[5] = '{op: 32'd3,          delay: 2,  st: 2'd0, data: 32'd0,        is_tick: 1'b1};
    vecs[6] = '{op: 32'hFFFF_FFFF,  delay: 1,  st: 2'd1, data: 32'd0,        is_tick: 1'b0};

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_opcode = '0;
    resp_ready = 1'b0;
    unit_stuck = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst opcode", dut_opcode, 32'd0);
    check("rst unit_resetn", {31'd0, unit_resetn}, 32'd0);
    check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst data", resp_data, 32'd0);
    check("rst status", {30'd0, resp_status}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst req_ready", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst unit_resetn", {31'd0, unit_resetn}, 32'd1);
    check("post_rst req_ready", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 7; i++) begin
      do_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].delay, 1'b0, 1'b0,
             vecs[i].st, vecs[i].data, vecs[i].is_tick);
    end

    // Reset in the middle of WAIT aborts the transaction.
    unit_stuck = 1'b1;
    req_valid  = 1'b1;
    req_opcode = 32'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midwait busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midwait_rst opcode", dut_opcode, 32'd0);
    check("midwait_rst unit_resetn", {31'd0, unit_resetn}, 32'd0);
    check("midwait_rst resp_valid", {31'd0, resp_valid}, 32'd0);
    check("midwait_rst busy", {31'd0, busy}, 32'd0);
    check("midwait_rst req_ready", {31'd0, req_ready}, 32'd0);
    check("midwait_rst status", {30'd0, resp_status}, 32'd0);
    rst        = 1'b0;
    unit_stuck = 1'b0;
    seen       = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (resp_valid === 1'b1) seen = 1'b1;
    end
    check("midwait no_resp", {31'd0, seen}, 32'd0);
    do_txn("after_rst_tick", 32'd3, 0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1);

`ifdef GPUINFO_CLIENT_TIMEOUT_EN
    unit_stuck = 1'b1;
    req_valid  = 1'b1;
    req_opcode = 32'd1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("tmo before unit_resetn", {31'd0, unit_resetn}, 32'd1);
    @(posedge clk); #1;
    check("tmo unit_resetn", {31'd0, unit_resetn}, 32'd0);
    check("tmo status", {30'd0, resp_status}, 32'd2);
    check("tmo data", resp_data, 32'd0);
    unit_stuck = 1'b0;
    seen       = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (resp_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("tmo resp_valid", {31'd0, seen}, 32'd1);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("tmo idle", {31'd0, busy}, 32'd0);
`endif

    for (int i = 0; i < 24; i++) begin
      case ($urandom % 6)
        0:       rop = 32'd0;
        1:       rop = 32'd1;
        2:       rop = 32'd2;
        3:       rop = 32'd3;
        default: rop = $urandom;
      endcase
      do_txn($sformatf("rnd%0d", i), rop, int'($urandom % 5), 1'b1, 1'b1, 2'd0, 32'd0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
